// File: rtl/io_ports_pkg.sv
// io_ports_pkg
//   Shared types and constants for the CPU I/O window responder
//   ($4014 sprite DMA, $4016/$4017 joypad ports).
//   - dma_state_t : sprite DMA sequencer states
//   - C_addr_*    : low five address bits of the decoded registers
//   - C_data_w / C_addr_w : host bus data and register-address widths
package io_ports_pkg;

    localparam int unsigned C_data_w = 8;
    localparam int unsigned C_addr_w = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

    localparam logic [C_addr_w-1:0] C_addr_dma  = 5'h14;
    localparam logic [C_addr_w-1:0] C_addr_pad0 = 5'h16;
    localparam logic [C_addr_w-1:0] C_addr_pad1 = 5'h17;

endpackage

// File: rtl/io_ports_if.sv
// io_ports_if
//   Host bus and DMA bus bundle between the CPU-side fabric and io_ports.
//   Host side : I_phy2, I_select, I_rdwr, I_addr, I_wr_data -> responder
//               O_rd_data, O_hit                            <- responder
//   DMA side  : O_ready, O_dma_active, O_dma_addr, O_dma_rdwr,
//               O_dma_wr_data                               <- responder
//               I_dma_rd_data                               -> responder
//   Modports: slave = io_ports view, master = host/fabric view.
interface io_ports_if;
    import io_ports_pkg::*;

    logic                I_phy2;
    logic                I_select;
    logic                I_rdwr;
    logic [C_addr_w-1:0] I_addr;
    logic [C_data_w-1:0] I_wr_data;
    logic [C_data_w-1:0] O_rd_data;
    logic                O_hit;

    logic                O_ready;
    logic                O_dma_active;
    logic [15:0]         O_dma_addr;
    logic                O_dma_rdwr;
    logic [C_data_w-1:0] O_dma_wr_data;
    logic [C_data_w-1:0] I_dma_rd_data;

    modport slave (
        input  I_phy2, I_select, I_rdwr, I_addr, I_wr_data, I_dma_rd_data,
        output O_rd_data, O_hit, O_ready, O_dma_active, O_dma_addr,
               O_dma_rdwr, O_dma_wr_data
    );

    modport master (
        output I_phy2, I_select, I_rdwr, I_addr, I_wr_data, I_dma_rd_data,
        input  O_rd_data, O_hit, O_ready, O_dma_active, O_dma_addr,
               O_dma_rdwr, O_dma_wr_data
    );

endinterface

// File: rtl/io_ports_pad_shifter.sv
// pad_shifter
//   One joypad serialiser. While the strobe is high the register follows the
//   live button state every clock and the serial bit is the live A button.
//   With the strobe low each shift moves the register right and feeds 1s in
//   from the top, so after eight shifts the port reads 1 forever.
//   Ports:
//     I_clock, I_reset : clock, asynchronous active-high reset
//     I_strobe         : shared $4016 strobe latch
//     I_load           : live button state (bit 0 = A ... bit 7 = Right)
//     I_shift          : a completed read of this port
//     O_bit            : serial bit presented on read data bit 0
module pad_shifter
    import io_ports_pkg::*;
(
    input  logic                I_clock,
    input  logic                I_reset,
    input  logic                I_strobe,
    input  logic [C_data_w-1:0] I_load,
    input  logic                I_shift,
    output logic                O_bit
);

    logic [C_data_w-1:0] sh_q;
    logic [C_data_w-1:0] sh_d;

    always_comb begin
        sh_d = sh_q;
        if (I_strobe) begin
            sh_d = I_load;
        end else if (I_shift) begin
            sh_d = {1'b1, sh_q[C_data_w-1:1]};
        end
    end

    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            sh_q <= '1;
        end else begin
            sh_q <= sh_d;
        end
    end

    // The register lags the pads by a clock, so strobe-high reads bypass it.
    assign O_bit = I_strobe ? I_load[0] : sh_q[0];

endmodule

// File: rtl/io_ports.sv
// io_ports
//   Responder for the CPU I/O window at $4014/$4016/$4017.
//   - $4016 write bit 0 sets the shared joypad strobe.
//   - $4016/$4017 reads return {P_open_bus[7:1], pad serial bit}.
//   - $4014 write of page P starts sprite DMA: the core is halted through
//     O_ready and the block masters the bus for 256 read/write pairs,
//     P:00..P:FF -> P_dma_target.
//   Ports:
//     I_clock, I_reset : clock, asynchronous active-high reset
//     I_pad0, I_pad1   : live button state of the two joypads
//     bus              : io_ports_if.slave host bus + DMA bus bundle
module io_ports
    import io_ports_pkg::*;
#(
    parameter logic [15:0]         P_dma_target = 16'h2004,
    parameter logic [C_data_w-1:0] P_open_bus   = 8'h40
)
(
    input  logic                I_clock,
    input  logic                I_reset,
    input  logic [C_data_w-1:0] I_pad0,
    input  logic [C_data_w-1:0] I_pad1,
    io_ports_if.slave           bus
);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_HALT  = HALT;
    localparam logic [2:0] S_ALIGN = ALIGN;
    localparam logic [2:0] S_READ  = READ;
    localparam logic [2:0] S_WRITE = WRITE;

    logic [2:0]          state_q,  state_d;
    logic                strobe_q, strobe_d;
    logic                par_q,    par_d;
    logic                ready_q,  ready_d;
    logic                active_q, active_d;
    logic [15:0]         addr_q,   addr_d;
    logic                rdwr_q,   rdwr_d;
    logic [C_data_w-1:0] wdata_q,  wdata_d;
    logic [7:0]          page_q,   page_d;
    logic [7:0]          idx_q,    idx_d;

    logic host_wr;
    logic host_rd;
    logic sel_pad0;
    logic sel_pad1;
    logic bit_pad0;
    logic bit_pad1;

    // Host accesses are blanked while DMA owns the bus.
    assign host_wr  = bus.I_select & bus.I_phy2 & ~bus.I_rdwr & ~active_q;
    assign host_rd  = bus.I_select & bus.I_rdwr & ~active_q;
    assign sel_pad0 = (bus.I_addr == C_addr_pad0);
    assign sel_pad1 = (bus.I_addr == C_addr_pad1);

    pad_shifter u_pad0 (
        .I_clock  (I_clock),
        .I_reset  (I_reset),
        .I_strobe (strobe_q),
        .I_load   (I_pad0),
        .I_shift  (host_rd & bus.I_phy2 & sel_pad0),
        .O_bit    (bit_pad0)
    );

    pad_shifter u_pad1 (
        .I_clock  (I_clock),
        .I_reset  (I_reset),
        .I_strobe (strobe_q),
        .I_load   (I_pad1),
        .I_shift  (host_rd & bus.I_phy2 & sel_pad1),
        .O_bit    (bit_pad1)
    );

    assign bus.O_hit     = host_rd & (sel_pad0 | sel_pad1);
    assign bus.O_rd_data = ~bus.O_hit ? '0 :
                           {P_open_bus[C_data_w-1:1], (sel_pad0 ? bit_pad0 : bit_pad1)};

    // Next-state logic: everything advances only on I_phy2 bus cycles, and
    // the registered DMA outputs are computed for the state being entered.
    always_comb begin
        state_d  = state_q;
        strobe_d = strobe_q;
        par_d    = par_q;
        ready_d  = ready_q;
        active_d = active_q;
        addr_d   = addr_q;
        rdwr_d   = rdwr_q;
        wdata_d  = wdata_q;
        page_d   = page_q;
        idx_d    = idx_q;

        if (host_wr && (bus.I_addr == C_addr_pad0)) begin
            strobe_d = bus.I_wr_data[0];
        end

        if (bus.I_phy2) begin
            par_d = ~par_q;
            case (state_q)
                S_IDLE: begin
                    if (host_wr && (bus.I_addr == C_addr_dma)) begin
                        page_d   = bus.I_wr_data;
                        idx_d    = 8'h00;
                        state_d  = S_HALT;
                        ready_d  = 1'b0;
                        active_d = 1'b1;
                        rdwr_d   = 1'b1;
                    end
                end
                S_HALT: begin
                    // An odd-parity halt cycle costs one extra alignment cycle.
                    if (par_q) begin
                        state_d = S_ALIGN;
                    end else begin
                        state_d = S_READ;
                        addr_d  = {page_q, idx_q};
                        rdwr_d  = 1'b1;
                    end
                end
                S_ALIGN: begin
                    state_d = S_READ;
                    addr_d  = {page_q, idx_q};
                    rdwr_d  = 1'b1;
                end
                S_READ: begin
                    state_d = S_WRITE;
                    addr_d  = P_dma_target;
                    rdwr_d  = 1'b0;
                    wdata_d = bus.I_dma_rd_data;
                end
                S_WRITE: begin
                    // idx wraps within the page; FF ends the transfer.
                    idx_d = idx_q + 8'd1;
                    if (idx_q == 8'hFF) begin
                        state_d  = S_IDLE;
                        ready_d  = 1'b1;
                        active_d = 1'b0;
                        rdwr_d   = 1'b1;
                    end else begin
                        state_d = S_READ;
                        addr_d  = {page_q, idx_q + 8'd1};
                        rdwr_d  = 1'b1;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    ready_d  = 1'b1;
                    active_d = 1'b0;
                    rdwr_d   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            state_q  <= S_IDLE;
            strobe_q <= 1'b0;
            par_q    <= 1'b0;
            ready_q  <= 1'b1;
            active_q <= 1'b0;
            addr_q   <= 16'h0000;
            rdwr_q   <= 1'b1;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            strobe_q <= strobe_d;
            par_q    <= par_d;
            ready_q  <= ready_d;
            active_q <= active_d;
            addr_q   <= addr_d;
            rdwr_q   <= rdwr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Page and index are only meaningful once a $4014 write has loaded them.
    always_ff @(posedge I_clock) begin
        page_q <= page_d;
        idx_q  <= idx_d;
    end

    assign bus.O_ready       = ready_q;
    assign bus.O_dma_active  = active_q;
    assign bus.O_dma_addr    = addr_q;
    assign bus.O_dma_rdwr    = rdwr_q;
    assign bus.O_dma_wr_data = wdata_q;

endmodule

// File: tb/tb_io_ports.sv
// tb_io_ports
//   Directed bench for io_ports. Stimulus pushes expected host-read results
//   and expected DMA write cycles into queues; a monitor on the falling edge
//   pops and compares whenever the DUT presents a host read or a DMA write.
module tb_io_ports;
    import io_ports_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pad0 = 8'h00;
    logic [7:0] pad1 = 8'h00;
    int         checks = 0;
    int         errors = 0;
    bit         par_m  = 1'b0;

    logic [8:0]  rd_q[$];   // {hit, rd_data}
    logic [23:0] dw_q[$];   // {addr, wr_data}

    io_ports_if bus_if ();

    io_ports #(.P_dma_target(16'h2004), .P_open_bus(8'h40)) dut (
        .I_clock (clk),
        .I_reset (rst),
        .I_pad0  (pad0),
        .I_pad1  (pad1),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    // Bench memory: page $03 holds its index, every other page the inverse.
    function automatic logic [7:0] mem(input logic [15:0] a);
        return (a[15:8] == 8'h03) ? a[7:0] : ~a[7:0];
    endfunction

    assign bus_if.I_dma_rd_data = mem(bus_if.O_dma_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One bus cycle: a phy2-low clock followed by the phy2 clock.
    task automatic bus(input logic sel, input logic rdwr, input logic [4:0] a, input logic [7:0] d);
        bus_if.I_select  = sel;
        bus_if.I_rdwr    = rdwr;
        bus_if.I_addr    = a;
        bus_if.I_wr_data = d;
        bus_if.I_phy2    = 1'b0;
        @(posedge clk); #1;
        bus_if.I_phy2    = 1'b1;
        @(posedge clk); #1;
        par_m = ~par_m;
        bus_if.I_phy2    = 1'b0;
        bus_if.I_select  = 1'b0;
        bus_if.I_rdwr    = 1'b1;
    endtask

    task automatic host_rd(input logic [4:0] a, input logic [8:0] exp);
        rd_q.push_back(exp);
        bus(1'b1, 1'b1, a, 8'h00);
    endtask

    task automatic start_dma(input logic [7:0] page, input bit halt_par);
        if (par_m == halt_par) bus(1'b0, 1'b1, 5'h00, 8'h00);
        for (int i = 0; i < 256; i++) dw_q.push_back({16'h2004, mem({page, i[7:0]})});
        bus(1'b1, 1'b0, 5'h14, page);
        chk("dma_halt_ready", {31'd0, bus_if.O_ready}, 32'd0);
    endtask

    task automatic dma(input logic [7:0] page, input bit halt_par, input int exp_len);
        int cnt;
        start_dma(page, halt_par);
        cnt = 0;
        while (bus_if.O_ready == 1'b0 && cnt < 1000) begin
            cnt++;
            bus(1'b0, 1'b1, 5'h00, 8'h00);
        end
        chk("dma_len", cnt, exp_len);
        chk("dma_active_end", {31'd0, bus_if.O_dma_active}, 32'd0);
        chk("dma_writes_left", dw_q.size(), 0);
        dw_q.delete();
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus_if.I_phy2) begin
                if (bus_if.I_select && bus_if.I_rdwr && !bus_if.O_dma_active) begin
                    if (rd_q.size() == 0) chk("host_rd_unexpected", 32'd1, 32'd0);
                    else chk("host_rd", {23'd0, bus_if.O_hit, bus_if.O_rd_data}, {23'd0, rd_q.pop_front()});
                end
                if (bus_if.O_dma_active && !bus_if.O_dma_rdwr) begin
                    if (dw_q.size() == 0) chk("dma_wr_unexpected", 32'd1, 32'd0);
                    else chk("dma_wr", {8'd0, bus_if.O_dma_addr, bus_if.O_dma_wr_data}, {8'd0, dw_q.pop_front()});
                end
            end
        end
    end

    // Stimulus
    initial begin
        bus_if.I_phy2    = 1'b0;
        bus_if.I_select  = 1'b0;
        bus_if.I_rdwr    = 1'b1;
        bus_if.I_addr    = 5'h00;
        bus_if.I_wr_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",  {31'd0, bus_if.O_ready}, 32'd1);
        chk("rst_active", {31'd0, bus_if.O_dma_active}, 32'd0);
        chk("rst_addr",   {16'd0, bus_if.O_dma_addr}, 32'd0);
        chk("rst_rdwr",   {31'd0, bus_if.O_dma_rdwr}, 32'd1);
        chk("rst_wdata",  {24'd0, bus_if.O_dma_wr_data}, 32'd0);
        rst   = 1'b0;
        par_m = 1'b0;

        // Shifters come out of reset as all ones.
        host_rd(5'h16, 9'h141);
        host_rd(5'h17, 9'h141);

        // Pad 0 serial sequence, with foreign accesses in the middle.
        pad0 = 8'b1000_0101;
        bus(1'b1, 1'b0, 5'h16, 8'h01);
        bus(1'b1, 1'b0, 5'h16, 8'h00);
        host_rd(5'h16, 9'h141);
        host_rd(5'h16, 9'h140);
        host_rd(5'h16, 9'h141);
        host_rd(5'h16, 9'h140);
        host_rd(5'h15, 9'h000);
        bus(1'b1, 1'b0, 5'h15, 8'h01);
        host_rd(5'h00, 9'h000);
        bus(1'b1, 1'b0, 5'h00, 8'h01);
        chk("foreign_ready", {31'd0, bus_if.O_ready}, 32'd1);
        chk("foreign_active", {31'd0, bus_if.O_dma_active}, 32'd0);
        host_rd(5'h16, 9'h140);
        host_rd(5'h16, 9'h140);
        host_rd(5'h16, 9'h140);
        host_rd(5'h16, 9'h141);
        host_rd(5'h16, 9'h141);
        host_rd(5'h16, 9'h141);

        // Strobe held high: live bit 0, no shift.
        bus(1'b1, 1'b0, 5'h16, 8'h01);
        pad1 = 8'hF1; host_rd(5'h17, 9'h141);
        pad1 = 8'hF0; host_rd(5'h17, 9'h140);
        pad1 = 8'hF1; host_rd(5'h17, 9'h141);
        pad1 = 8'hFE;
        bus(1'b1, 1'b0, 5'h16, 8'h00);
        host_rd(5'h17, 9'h140);
        host_rd(5'h17, 9'h141);
        chk("rd_queue_empty", rd_q.size(), 0);

        // Sprite DMA, even and odd halt parity.
        dma(8'h03, 1'b0, 513);
        dma(8'h03, 1'b1, 514);

        // Reset in the middle of a transfer.
        start_dma(8'h03, 1'b0);
        repeat (100) bus(1'b0, 1'b1, 5'h00, 8'h00);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("midrst_ready",  {31'd0, bus_if.O_ready}, 32'd1);
        chk("midrst_active", {31'd0, bus_if.O_dma_active}, 32'd0);
        chk("midrst_addr",   {16'd0, bus_if.O_dma_addr}, 32'd0);
        chk("midrst_rdwr",   {31'd0, bus_if.O_dma_rdwr}, 32'd1);
        chk("midrst_wdata",  {24'd0, bus_if.O_dma_wr_data}, 32'd0);
        dw_q.delete();
        @(posedge clk); #1;
        rst   = 1'b0;
        par_m = 1'b0;
        dma(8'h05, 1'b0, 513);

        host_rd(5'h16, 9'h141);
        repeat (4) @(posedge clk);
        chk("final_rd_queue", rd_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_ports.md
# io_ports

Host-bus responder for the CPU I/O window at $4014/$4016/$4017, beside the APU in the `W_apu_select` region. Serialises two parallel joypad states through the $4016/$4017 strobe/shift protocol. Performs sprite DMA on a $4014 write: halts the core via `I_ready`, then masters the bus itself for 256 read/write pairs into $2004. The top-level muxes `O_dma_*` onto the host bus while `O_dma_active` is high.

## Interface
- `P_dma_target`, 16'h2004: write address for every DMA write cycle.
- `P_open_bus`, 8'h40: upper-bit pattern returned with pad reads; bit 0 is replaced by the pad bit.
- `I_clock`  in  1  system clock.
- `I_reset`  in  1  system reset. One clock; reset is asynchronous and active-high.
- `I_phy2`  in  1  bus-cycle strobe; a CPU bus cycle completes on the clock edge where `I_phy2`=1.
- `I_select`  in  1  APU/IO window select from the host address decoder.
- `I_rdwr`  in  1  1=read, 0=write.
- `I_addr`  in  5  `W_core_addr[4:0]`.
- `I_wr_data`  in  8  host write data.
- `O_rd_data`  out  8  read data. Valid when `O_hit`=1, otherwise 8'h00.
- `O_hit`  out  1  a current read targets $4016 or $4017.
- `I_pad0` / `I_pad1`  in  8  live button state, 1=pressed. Bit order: 0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right.
- `O_ready`  out  1  to core `I_ready`; 0 halts the core.
- `O_dma_active`  out  1  DMA owns the host bus.
- `O_dma_addr`  out  16  DMA bus address.
- `O_dma_rdwr`  out  1  DMA direction.
- `O_dma_wr_data`  out  8  DMA write data.
- `I_dma_rd_data`  in  8  bus read data while DMA is active.

## Operation
- Host write: accepted when `I_select & I_phy2 & ~I_rdwr`. Host read: `I_select & I_rdwr`. Host accesses are ignored while `O_dma_active`=1.
- $4016 write: `strobe` <= `I_wr_data[0]`. The register is shared by both pads.
- While `strobe`=1, both shifters reload from `I_pad0`/`I_pad1` every clock.
- $4016/$4017 read (combinational): `O_rd_data` = {`P_open_bus[7:1]`, shifter[0]}.
- With `strobe`=0, the read completing at `I_phy2` shifts that pad's register right and fills bit 7 with 1. After 8 reads the pad bit reads 1 indefinitely.
- With `strobe`=1, a read returns live `I_pad[0]` and does not shift.
- Parity bit `par` toggles on every `I_phy2` cycle. It resets to 0.
- $4014 write of P: latch `page`<=P, `idx`<=0, FSM IDLE→HALT.
- FSM states, advancing only on `I_phy2` cycles:
  - IDLE: `O_ready`=1, `O_dma_active`=0.
  - HALT: one bus cycle, no bus access. Exit to ALIGN if `par`=1 during HALT, else to READ.
  - ALIGN: one idle bus cycle, then READ.
  - READ: `O_dma_addr`={page,idx}, `O_dma_rdwr`=1. Capture `I_dma_rd_data` into `data`. Go to WRITE.
  - WRITE: `O_dma_addr`=`P_dma_target`, `O_dma_rdwr`=0, `O_dma_wr_data`=`data`, `idx`++. If `idx` was 8'hFF go to IDLE, else READ.
- `O_ready`=0 and `O_dma_active`=1 in HALT, ALIGN, READ and WRITE.
- `idx` is 8 bits. The FSM reads exactly bytes page:00..page:FF; there is no carry into the page.

## Timing
- Reset values: state IDLE, `O_ready`=1, `O_dma_active`=0, `O_dma_addr`=0, `O_dma_rdwr`=1, `O_dma_wr_data`=0, `strobe`=0, shifters 8'hFF, `par`=0. `O_hit`/`O_rd_data` are combinational from the bus.
- All FSM outputs are registered; they change on the clock after the `I_phy2` edge that commits the transition.
- DMA length after the $4014 write cycle: 513 bus cycles if `par`=0 in HALT, otherwise 514. `O_ready` returns to 1 on the clock following the final WRITE.
- Reset mid-DMA: outputs return to reset values immediately and asynchronously. The partial transfer is abandoned.
- A $4014 write while the FSM is not IDLE is impossible because the core is halted; if one arrives anyway, it is ignored.
- Between `I_phy2` pulses, the state and outputs hold.

## Structure
- Package `io_ports_pkg`:
  - `dma_state_t` enum {IDLE, HALT, ALIGN, READ, WRITE}.
  - Constants `C_addr_dma`=5'h14, `C_addr_pad0`=5'h16, `C_addr_pad1`=5'h17.
- Sub-module `pad_shifter`, instantiated twice:
  - Ports: clock, reset, strobe, load data, shift enable, serial bit.

## Test plan
- `I_pad0`=8'b1000_0101, write $4016=1 then 0, 10 reads of $4016 → bit0 sequence 1,0,1,0,0,0,0,1,1,1; `O_rd_data` is 8'h41 or 8'h40 accordingly.
- Strobe held at 1, `I_pad1` toggles bit 0, three reads of $4017 → each read returns live bit 0 with no shift. After strobe=0, the first read returns current `I_pad1[0]`.
- Preload page $03 with data = index; write $4014=8'h03 with `par`=0 → 513 halt cycles, 256 writes to $2004 carrying 00..FF in order, `O_ready` rises afterwards.
- Same transfer with `par`=1 at HALT → one ALIGN cycle, 514 halt cycles total, write data identical.
- Assert `I_reset` at DMA cycle 100 → immediately `O_ready`=1, `O_dma_active`=0. A fresh $4014 write then performs a full 256-byte transfer.
- Reads and writes of $4015 and $4000 → `O_hit`=0, `O_rd_data`=8'h00, shifters and FSM unchanged.
